// File: rtl/outstream_ctrl.sv
// Frame sequencer: passes one frame of stencil beats from in_* to an AXI-stream-style sink, walking a 4-D index to place tlast.
// Optional macro OUTSTREAM_CTRL_SKID_EN inserts a registered 2-entry skid slice between in_* and t*.
module outstream_ctrl #(
    parameter int IMG_EXTENT_0 = 256,
    parameter int IMG_EXTENT_1 = 256,
    parameter int IMG_EXTENT_2 = 1,
    parameter int IMG_EXTENT_3 = 1,
    parameter int ST_EXTENT_0  = 1,
    parameter int ST_EXTENT_1  = 1,
    parameter int ST_EXTENT_2  = 1,
    parameter int ST_EXTENT_3  = 1,
    parameter int DATA_SIZE    = 8,
    localparam int DW = DATA_SIZE * ST_EXTENT_0 * ST_EXTENT_1 * ST_EXTENT_2 * ST_EXTENT_3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_in,
    input  logic          stop_in,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] tdata,
    output logic          tvalid,
    input  logic          tready,
    output logic          tlast,
    output logic          busy,
    output logic          done_out,
    output logic [31:0]   beat_cnt
);

    localparam int IW0 = $clog2(IMG_EXTENT_0 + 1);
    localparam int IW1 = $clog2(IMG_EXTENT_1 + 1);
    localparam int IW2 = $clog2(IMG_EXTENT_2 + 1);
    localparam int IW3 = $clog2(IMG_EXTENT_3 + 1);
    localparam logic [IW0-1:0] LAST0 = IW0'(IMG_EXTENT_0 - ST_EXTENT_0);
    localparam logic [IW1-1:0] LAST1 = IW1'(IMG_EXTENT_1 - ST_EXTENT_1);
    localparam logic [IW2-1:0] LAST2 = IW2'(IMG_EXTENT_2 - ST_EXTENT_2);
    localparam logic [IW3-1:0] LAST3 = IW3'(IMG_EXTENT_3 - ST_EXTENT_3);
    localparam logic [IW0-1:0] STEP0 = IW0'(ST_EXTENT_0);
    localparam logic [IW1-1:0] STEP1 = IW1'(ST_EXTENT_1);
    localparam logic [IW2-1:0] STEP2 = IW2'(ST_EXTENT_2);
    localparam logic [IW3-1:0] STEP3 = IW3'(ST_EXTENT_3);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW0-1:0]  idx0_r;
    logic [IW1-1:0]  idx1_r;
    logic [IW2-1:0]  idx2_r;
    logic [IW3-1:0]  idx3_r;
    logic [31:0]     beat_cnt_r;
    logic            busy_r;
    logic            done_r;

    logic            wrap0_s;
    logic            wrap1_s;
    logic            wrap2_s;
    logic            wrap3_s;
    logic            at_last_s;
    logic            adv_s;
    logic            out_xfer_s;
    logic            out_last_s;

    // Wrap detection; a unit extent yields a constant-0 index that always wraps.
    always_comb begin
        wrap0_s   = (idx0_r == LAST0);
        wrap1_s   = (idx1_r == LAST1);
        wrap2_s   = (idx2_r == LAST2);
        wrap3_s   = (idx3_r == LAST3);
        at_last_s = wrap0_s & wrap1_s & wrap2_s & wrap3_s;
    end

`ifdef OUTSTREAM_CTRL_SKID_EN
    logic [DW-1:0] tdata_r;
    logic [DW-1:0] skid_data_r;
    logic          tvalid_r;
    logic          tlast_r;
    logic          skid_valid_r;
    logic          skid_last_r;
    logic          in_ready_r;
    logic          in_final_r;
    logic          push_s;
    logic          skid_next_s;
    logic          final_next_s;
    logic          run_next_s;

    // The index advances on input acceptance; in_ready is only ever high in RUN.
    always_comb begin
        push_s       = in_valid & in_ready_r;
        adv_s        = push_s;
        out_xfer_s   = tvalid_r & tready;
        out_last_s   = tlast_r;
        skid_next_s  = (tvalid_r && !tready) ? (skid_valid_r | push_s) : 1'b0;
        final_next_s = in_final_r | (push_s & at_last_s);
        if (state_r == S_IDLE) begin
            run_next_s = start_in & ~stop_in;
        end else if (state_r == S_RUN) begin
            run_next_s = ~stop_in & ~(out_xfer_s & out_last_s);
        end else begin
            run_next_s = 1'b0;
        end
    end

    // Output register plus one skid entry; leaving RUN discards anything buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tdata_r      <= '0;
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            skid_data_r  <= '0;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
            in_ready_r   <= 1'b0;
            in_final_r   <= 1'b0;
        end else if (!run_next_s) begin
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b0;
            in_final_r   <= 1'b0;
        end else begin
            if (!tvalid_r || out_xfer_s) begin
                if (skid_valid_r) begin
                    tdata_r      <= skid_data_r;
                    tlast_r      <= skid_last_r;
                    tvalid_r     <= 1'b1;
                    skid_valid_r <= 1'b0;
                end else if (push_s) begin
                    tdata_r  <= in_data;
                    tlast_r  <= at_last_s;
                    tvalid_r <= 1'b1;
                end else begin
                    tvalid_r <= 1'b0;
                    tlast_r  <= 1'b0;
                end
            end else if (push_s) begin
                skid_data_r  <= in_data;
                skid_last_r  <= at_last_s;
                skid_valid_r <= 1'b1;
            end
            in_final_r <= final_next_s;
            in_ready_r <= ~skid_next_s & ~final_next_s;
        end
    end

    assign tdata    = tdata_r;
    assign tvalid   = tvalid_r;
    assign tlast    = tlast_r;
    assign in_ready = in_ready_r;
`else
    logic run_s;

    // Zero-latency pass-through: one handshake drives both sides.
    always_comb begin
        run_s      = (state_r == S_RUN);
        out_xfer_s = in_valid & tready & run_s;
        adv_s      = out_xfer_s;
        out_last_s = at_last_s;
    end

    assign tvalid   = in_valid & run_s;
    assign in_ready = tready & run_s;
    assign tdata    = run_s ? in_data : '0;
    assign tlast    = in_valid & run_s & at_last_s;
`endif

    // Frame FSM with index walk, beat counter and registered busy/done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            idx0_r     <= '0;
            idx1_r     <= '0;
            idx2_r     <= '0;
            idx3_r     <= '0;
            beat_cnt_r <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start_in && !stop_in) begin
                        state_r    <= S_RUN;
                        busy_r     <= 1'b1;
                        idx0_r     <= '0;
                        idx1_r     <= '0;
                        idx2_r     <= '0;
                        idx3_r     <= '0;
                        beat_cnt_r <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (out_xfer_s) begin
                        beat_cnt_r <= beat_cnt_r + 32'd1;
                    end
                    // Abort wins over a simultaneous final beat: counted, but no done pulse.
                    if (stop_in) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        idx0_r  <= '0;
                        idx1_r  <= '0;
                        idx2_r  <= '0;
                        idx3_r  <= '0;
                    end else begin
                        if (adv_s) begin
                            idx0_r <= wrap0_s ? '0 : idx0_r + STEP0;
                            if (wrap0_s) begin
                                idx1_r <= wrap1_s ? '0 : idx1_r + STEP1;
                                if (wrap1_s) begin
                                    idx2_r <= wrap2_s ? '0 : idx2_r + STEP2;
                                    if (wrap2_s) begin
                                        idx3_r <= wrap3_s ? '0 : idx3_r + STEP3;
                                    end
                                end
                            end
                        end
                        if (out_xfer_s && out_last_s) begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done_out = done_r;
    assign beat_cnt = beat_cnt_r;

endmodule

// File: tb/tb_outstream_ctrl.sv
// Bench for outstream_ctrl: random handshakes against a frame-level model (beat queue, beat count, tlast position).
module tb_outstream_ctrl;
    localparam int DW = 16;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_in;
    logic          stop_in;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic          done_out;
    logic [31:0]   beat_cnt;

    logic          o_start;
    logic          o_stop;
    logic [7:0]    o_in_data;
    logic          o_in_valid;
    logic          o_in_ready;
    logic [7:0]    o_tdata;
    logic          o_tvalid;
    logic          o_tready;
    logic          o_tlast;
    logic          o_busy;
    logic          o_done;
    logic [31:0]   o_beat_cnt;

    always #5 clk = ~clk;

    outstream_ctrl #(
        .IMG_EXTENT_0(8), .IMG_EXTENT_1(2), .IMG_EXTENT_2(1), .IMG_EXTENT_3(1),
        .ST_EXTENT_0(2), .ST_EXTENT_1(1), .ST_EXTENT_2(1), .ST_EXTENT_3(1),
        .DATA_SIZE(8)
    ) dut (
        .clk(clk), .reset(reset), .start_in(start_in), .stop_in(stop_in),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
        .busy(busy), .done_out(done_out), .beat_cnt(beat_cnt)
    );

    outstream_ctrl #(
        .IMG_EXTENT_0(1), .IMG_EXTENT_1(1), .IMG_EXTENT_2(1), .IMG_EXTENT_3(1),
        .ST_EXTENT_0(1), .ST_EXTENT_1(1), .ST_EXTENT_2(1), .ST_EXTENT_3(1),
        .DATA_SIZE(8)
    ) one (
        .clk(clk), .reset(reset), .start_in(o_start), .stop_in(o_stop),
        .in_data(o_in_data), .in_valid(o_in_valid), .in_ready(o_in_ready),
        .tdata(o_tdata), .tvalid(o_tvalid), .tready(o_tready), .tlast(o_tlast),
        .busy(o_busy), .done_out(o_done), .beat_cnt(o_beat_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference state
    logic [DW-1:0] q[$];
    bit            active = 1'b0;
    bit            done_exp = 1'b0;
    bit            cnt_known = 1'b1;
    int            beats = 0;
    int            frame_lasts = 0;
    bit            hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    bit            pend = 1'b0;
    logic [DW-1:0] src = '0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            dur = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit start, input bit stop, input int rdy_pct, input int val_pct);
        bit xfer;
        bit last_exp;
        bit done_nxt;
        @(negedge clk);
        cyc++;
        start_in = start;
        stop_in  = stop;
        tready   = ($urandom_range(99) < rdy_pct);
        if (!pend && ($urandom_range(99) < val_pct)) begin
            pend = 1'b1;
            src  = DW'($urandom);
        end
        in_valid = pend;
        in_data  = src;
        #1;
        chk("busy", 64'(busy), 64'(active));
        chk("done_out", 64'(done_out), 64'(done_exp));
        if (done_exp) dur = cyc - start_cyc;
        if (cnt_known) chk("beat_cnt", 64'(beat_cnt), 64'(beats));
        if (hold) begin
            chk("hold_valid", 64'(tvalid), 64'(1));
            chk("hold_data", 64'(tdata), 64'(hold_data));
        end
        if (!tvalid) chk("tlast_unqualified", 64'(tlast), 64'(0));
        if (in_valid && in_ready) begin
            q.push_back(in_data);
            pend = 1'b0;
        end
        xfer     = tvalid && tready;
        last_exp = (beats == N - 1);
        done_nxt = 1'b0;
        if (xfer) begin
            if (q.size() == 0) chk("beat_present", 64'(0), 64'(1));
            else chk("tdata", 64'(tdata), 64'(q.pop_front()));
            chk("tlast", 64'(tlast), 64'(last_exp));
            if (tlast) frame_lasts++;
            beats++;
            done_nxt = last_exp && !stop;
        end
        hold      = tvalid && !tready && !stop && active;
        hold_data = tdata;
        if (active) begin
            if (stop) begin
                active    = 1'b0;
                cnt_known = 1'b0;
                hold      = 1'b0;
                q.delete();
            end else if (xfer && last_exp) begin
                active = 1'b0;
            end
        end else if (!done_exp && start && !stop) begin
            active      = 1'b1;
            beats       = 0;
            frame_lasts = 0;
            cnt_known   = 1'b1;
            start_cyc   = cyc;
            q.delete();
        end
        done_exp = done_nxt;
    endtask

    task automatic run_frame(input int rdy, input int val, input bit spurious);
        int n = 0;
        cycle(1'b1, 1'b0, rdy, val);
        while ((active || done_exp) && n < 400) begin
            cycle(spurious && active && ($urandom_range(9) == 0), 1'b0, rdy, val);
            n++;
        end
        chk("frame_complete", 64'(active), 64'(0));
        chk("tlast_once", 64'(frame_lasts), 64'(1));
        chk("frame_beats", 64'(beat_cnt), 64'(N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; start_in = 1'b0; stop_in = 1'b0; in_valid = 1'b0; in_data = '0; tready = 1'b0;
        o_start = 1'b0; o_stop = 1'b0; o_in_data = 8'hA5; o_in_valid = 1'b1; o_tready = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'(0));
        chk("rst_tlast", 64'(tlast), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done_out), 64'(0));
        chk("rst_beat_cnt", 64'(beat_cnt), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Basic frame at full rate, then throughput bound.
        run_frame(100, 100, 1'b0);
        chk("full_rate_cycles", 64'(dur <= 10), 64'(1));

        // Backpressure with spurious mid-frame starts.
        for (int f = 0; f < 4; f++) begin
            run_frame(40, 70, 1'b1);
            repeat (2) cycle(1'b0, 1'b0, 50, 50);
        end

        // Start and stop together in IDLE: stay idle.
        cycle(1'b1, 1'b1, 50, 50);
        repeat (2) cycle(1'b0, 1'b0, 50, 50);

        // Abort after beat 3, then a fresh frame.
        cycle(1'b1, 1'b0, 100, 100);
        n = 0;
        while (beats < 3 && n < 50) begin
            cycle(1'b0, 1'b0, 100, 100);
            n++;
        end
        chk("abort_reached_beat3", 64'(beats), 64'(3));
        cycle(1'b0, 1'b1, 100, 100);
        repeat (3) cycle(1'b0, 1'b0, 100, 100);
        run_frame(100, 100, 1'b0);

        // Reset mid-frame.
        cycle(1'b1, 1'b0, 50, 80);
        repeat (5) cycle(1'b0, 1'b0, 50, 80);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(tvalid), 64'(0));
        chk("mid_rst_tlast", 64'(tlast), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_beat_cnt", 64'(beat_cnt), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_tdata", 64'(tdata), 64'(0));
        active = 1'b0; done_exp = 1'b0; cnt_known = 1'b1; beats = 0; hold = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        run_frame(60, 60, 1'b0);

        // Single-beat frame on the unit-extent instance.
        @(negedge clk);
        o_start = 1'b1;
        @(negedge clk);
        o_start = 1'b0;
        #1;
        n = 0;
        while (!o_tvalid && n < 5) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("one_tvalid", 64'(o_tvalid), 64'(1));
        chk("one_tlast", 64'(o_tlast), 64'(1));
        chk("one_tdata", 64'(o_tdata), 64'(8'hA5));
        @(negedge clk);
        #1;
        chk("one_done", 64'(o_done), 64'(1));
        chk("one_beat_cnt", 64'(o_beat_cnt), 64'(1));
        @(negedge clk);
        #1;
        chk("one_done_single", 64'(o_done), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
